// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory-access stage: funct3 size/sign
// encodings, ResultSrc encodings, the MEM FSM state type and a helper that
// classifies an access by its size.
package riscv_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // ResultSrc encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Stores only know SB/SH and treat everything else as a word; loads also
  // map the unsigned byte/half encodings onto their sizes.
  function automatic acc_size_e access_size(input logic [2:0] funct3,
                                            input logic       is_store);
    if (is_store) begin
      case (funct3)
        F3_B:    return SZ_BYTE;
        F3_H:    return SZ_HALF;
        default: return SZ_WORD;
      endcase
    end
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request/ready handshake with
// word address, lane-replicated write data and byte enables.
// master = the pipeline (mem_stage), slave = the memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage_load_store_align.sv
// load_store_align: purely combinational byte-lane logic for the MEM stage.
// Generates store byte enables / replicated write data, extracts and
// extends load data, and flags misaligned accesses.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (misalign detection).
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_is_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  acc_size_e   w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size = access_size(i_funct3, i_is_store);
  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Store lanes: replicate the datum across the word, enable only its bytes
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    if (i_is_store) begin
      case (w_size)
        SZ_BYTE: begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {4{i_wdata[7:0]}};
        end
        SZ_HALF: begin
          o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: o_be = 4'b1111;
      endcase
    end
  end

  // Load extraction: pick the addressed byte/half and sign- or zero-extend
  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign o_misalign = ((w_size == SZ_HALF) && i_addr_lo[0]) ||
                      ((w_size == SZ_WORD) && (i_addr_lo != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32I pipeline.
// Issues data-memory requests with a req/ready handshake, stalls the front
// of the pipe while memory is busy, aborts with a bus error after TIMEOUT
// request cycles, and registers results into MEM/WB.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (suppress and flag
// misaligned halfword/word accesses).
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255  // 2..65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ALUResultM,
  input  logic [31:0]        WriteDataM,
  input  logic [31:0]        PCPlus4M,
  input  logic [4:0]         RdM,
  input  logic               RegWriteM,
  input  logic               MemWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic [2:0]         funct3M,
  mem_stage_if.master        dmem,
  output logic               StallM,
  output logic [31:0]        ALUResultW,
  output logic [31:0]        ReadDataW,
  output logic [31:0]        PCPlus4W,
  output logic [4:0]         RdW,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic               BusErrW,
  output logic               MisalignW
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  // The IDLE cycle is the first request cycle and WAIT starts with the
  // counter at 0, so request cycle n sits at count n-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  mem_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic        w_is_load;
  logic        w_misalign;
  logic        w_access;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  load_store_align u_align (
    .i_funct3    (funct3M),
    .i_addr_lo   (ALUResultM[1:0]),
    .i_is_store  (MemWriteM),
    .i_wdata     (WriteDataM),
    .i_rdata     (dmem.dmem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data),
    .o_misalign  (w_misalign)
  );

  assign w_is_load = (ResultSrcM == RES_MEM);
  assign w_access  = (MemWriteM || w_is_load) && !w_misalign;
  // Ready in the timeout cycle completes the access normally.
  assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_LAST) && !dmem.dmem_ready;

  assign dmem.dmem_req   = !rst && ((r_state == WAIT) || w_access);
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = {ALUResultM[31:2], 2'b00};
  assign dmem.dmem_wdata = w_wdata;
  assign dmem.dmem_be    = w_be;

  assign StallM = !rst && w_access && !dmem.dmem_ready && !w_timeout;

  // Handshake FSM and request-cycle counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access && !dmem.dmem_ready) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (dmem.dmem_ready || w_timeout) r_state <= IDLE;
          else                              r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign;
  assign MisalignW = r_misalign;
`else
  assign MisalignW = 1'b0;
`endif

  // MEM/WB register: capture when not stalled, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (rst || StallM) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      BusErrW    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= (w_is_load && !w_misalign) ? w_load_data : 32'h0;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM && !w_timeout && !w_misalign;
      ResultSrcW <= ResultSrcM;
      BusErrW    <= w_timeout;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign <= w_misalign;
`endif
    end
  end

endmodule
